uart_recv: RTL and testbench

UART_RECV -- requirements
Module: uart_recv

---
 rtl/uart_recv.sv | 161 ++++++++++++++++
 tb/tb_uart_recv.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// UART receiver: 8N1-style framing, MSB first, with overrun and framing error pulses.
// Define UART_RECV_MAJORITY_EN for 2-of-3 majority sampling around each decision point.
module uart_recv #(
  parameter int CLKS_PER_BIT = 16,
  parameter int W            = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RxD,
  input  logic         rd_ack,
  output logic [W-1:0] data_out,
  output logic         rx_full,
  output logic         data_valid,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nx;

  logic          rx_q;
  logic          rx_s;
  logic          rx_d1;
  logic          sample;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bits, bits_nx;
  logic [W-1:0]  shreg, shreg_nx;
  logic [W-1:0]  data_nx;
  logic          full_nx;
  logic          dv_nx;
  logic          fe_nx;
  logic          ov_nx;

  // rx_d1 doubles as the previous rx_s for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q  <= 1'b1;
      rx_s  <= 1'b1;
      rx_d1 <= 1'b1;
    end else begin
      rx_q  <= RxD;
      rx_s  <= rx_q;
      rx_d1 <= rx_s;
    end
  end

`ifdef UART_RECV_MAJORITY_EN
  logic rx_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_d2 <= 1'b1;
    else     rx_d2 <= rx_d1;
  end

  assign sample = (rx_s & rx_d1) |
                  (rx_s & rx_d2) |
                  (rx_d1 & rx_d2);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bits       <= '0;
      shreg      <= '0;
      data_out   <= '0;
      rx_full    <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bits       <= bits_nx;
      shreg      <= shreg_nx;
      data_out   <= data_nx;
      rx_full    <= full_nx;
      data_valid <= dv_nx;
      frame_err  <= fe_nx;
      overrun    <= ov_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bits_nx  = bits;
    shreg_nx = shreg;
    data_nx  = data_out;
    full_nx  = rx_full & ~rd_ack;
    dv_nx    = 1'b0;
    fe_nx    = 1'b0;
    ov_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx  = '0;
        bits_nx = '0;
        if (rx_d1 && !rx_s) state_nx = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nx   = '0;
          state_nx = sample ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_nx   = '0;
          shreg_nx = W'({shreg, sample});
          if (bits == LAST) begin
            bits_nx  = '0;
            state_nx = STOP;
          end else begin
            bits_nx = bits + 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          if (sample) begin
            // a simultaneous ack consumes the old byte, so no overrun
            data_nx = shreg;
            dv_nx   = 1'b1;
            ov_nx   = rx_full & ~rd_ack;
            full_nx = 1'b1;
          end else begin
            fe_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Scoreboard bench for uart_recv: frames, overrun, framing error,
// false start, sample spikes, mid-frame reset and a stuck-low line.
module tb_uart_recv;

  localparam int CPB = 16;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       RxD    = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] data_out;
  logic       rx_full;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  logic [7:0] exp_q[$];

  uart_recv #(
    .CLKS_PER_BIT(CPB),
    .W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .RxD(RxD),
    .rd_ack(rd_ack),
    .data_out(data_out),
    .rx_full(rx_full),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        dv_cnt++;
        if (exp_q.size() == 0)
          check("dv_unexpected", 32'd1, 32'd0);
        else
          check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // start bit, MSB-first data, stop bit; optional spike on each data
  // bit centre and optional early abort at a given cycle index
  task automatic send(input logic [7:0] d,
                      input logic       stop_bit,
                      input bit         spike,
                      input int         abort_at);
    logic [9:0] fr;
    fr = {1'b0, d, stop_bit};
    for (int s = 0; s < 10 * CPB; s++) begin
      int   b;
      int   c;
      logic v;
      b = s / CPB;
      c = s % CPB;
      if (s == abort_at) return;
      v = fr[9-b];
      if (spike && b >= 1 && b <= 8 && c == CPB / 2) v = ~v;
      RxD = v;
      @(posedge clk);
      #1;
    end
    RxD = 1'b1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    idle(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d0;
    int         f0;
    int         o0;
    int         n;
    logic [7:0] spk;

    idle(3);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_rx_full", 32'(rx_full), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_fe", 32'(frame_err), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(5);

    d0 = dv_cnt;
    f0 = fe_cnt;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0, -1);
    idle(4);
    check("a5_dv_count", 32'(dv_cnt - d0), 32'd1);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_rx_full", 32'(rx_full), 32'd1);
    check("a5_fe_count", 32'(fe_cnt - f0), 32'd0);
    ack();
    check("a5_ack_clear", 32'(rx_full), 32'd0);

    o0 = ov_cnt;
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, 1'b0, -1);
    idle(2);
    check("3c_rx_full", 32'(rx_full), 32'd1);
    check("3c_no_ovr", 32'(ov_cnt - o0), 32'd0);
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, 1'b0, -1);
    idle(4);
    check("c3_ovr_count", 32'(ov_cnt - o0), 32'd1);
    check("c3_data_out", 32'(data_out), 32'hC3);
    check("c3_rx_full", 32'(rx_full), 32'd1);
    ack();
    check("c3_ack_clear", 32'(rx_full), 32'd0);

    d0 = dv_cnt;
    f0 = fe_cnt;
    send(8'hFF, 1'b0, 1'b0, -1);
    idle(4);
    check("ff_fe_count", 32'(fe_cnt - f0), 32'd1);
    check("ff_dv_count", 32'(dv_cnt - d0), 32'd0);
    check("ff_data_keep", 32'(data_out), 32'hC3);
    check("ff_rx_full", 32'(rx_full), 32'd0);

    d0 = dv_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    RxD = 1'b0;
    idle(4);
    RxD = 1'b1;
    check("glitch_busy_seen", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 10) begin
      idle(1);
      n++;
    end
    check("glitch_busy_drop", 32'(busy), 32'd0);
    idle(4);
    check("glitch_dv", 32'(dv_cnt - d0), 32'd0);
    check("glitch_fe", 32'(fe_cnt - f0), 32'd0);
    check("glitch_ov", 32'(ov_cnt - o0), 32'd0);

`ifdef UART_RECV_MAJORITY_EN
    spk = 8'h5A;
`else
    spk = 8'hA5;
`endif
    exp_q.push_back(spk);
    send(8'h5A, 1'b1, 1'b1, -1);
    idle(4);
    check("spike_data_out", 32'(data_out), 32'(spk));
    ack();

    d0 = dv_cnt;
    send(8'h81, 1'b1, 1'b0, CPB * 5 + 4);
    rst = 1'b1;
    RxD = 1'b1;
    idle(3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_rx_full", 32'(rx_full), 32'd0);
    rst = 1'b0;
    idle(20);
    check("midrst_no_dv", 32'(dv_cnt - d0), 32'd0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 1'b0, -1);
    idle(4);
    check("81_dv_count", 32'(dv_cnt - d0), 32'd1);
    check("81_data_out", 32'(data_out), 32'h81);
    ack();

    d0 = dv_cnt;
    f0 = fe_cnt;
    RxD = 1'b0;
    idle(400);
    check("low_fe_count", 32'(fe_cnt - f0), 32'd1);
    check("low_busy", 32'(busy), 32'd0);
    RxD = 1'b1;
    idle(5);
    check("low_dv_count", 32'(dv_cnt - d0), 32'd0);
    check("low_idle_busy", 32'(busy), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
